// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//   Shared definitions for the front-panel button conditioning logic.
//   - Board clock frequency and the default debounce/repeat timings derived
//     from it (10 ms debounce, 1 s repeat delay, 250 ms repeat period).
//   - Button FSM state encoding.
//   - Helper to size a counter that must hold values 0..n.
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int CLK_HZ = 50_000_000;

    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = CLK_HZ;          // 1 s
    localparam int DEF_REPEAT_PERIOD   = CLK_HZ / 4;      // 250 ms

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } btn_state_t;

    // Bits needed for a counter that must represent 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_conditioner_pulse_timer.sv
// -----------------------------------------------------------------------------
// pulse_timer
//   Loadable down-counter with a terminal-count strobe, used for both the
//   repeat delay and the repeat period.
//
//   Ports
//     i_clk        : system clock, rising edge
//     i_rst_n      : asynchronous active-low reset, clears the count
//     i_load       : load i_load_val this edge (overrides counting, no strobe)
//     i_load_val   : value loaded by i_load
//     i_en         : count this edge
//     i_reload_val : value reloaded automatically after the count reaches 0
//     o_tc         : high during the cycle in which an enabled count sits at 0;
//                    the edge ending that cycle reloads i_reload_val
//
//   A load value of L produces o_tc on the (L+1)-th enabled edge after load.
// -----------------------------------------------------------------------------
module pulse_timer
    import clock_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_reload_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;
    logic         w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_tc   = i_en && w_zero && !i_load;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            if (w_zero) begin
                r_cnt <= i_reload_val;
            end else begin
                r_cnt <= r_cnt - W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Debounces a synchronized button level and produces a clean level plus
//   single-cycle press, release and auto-repeat strobes.
//
//   Parameters
//     DEBOUNCE_CYCLES : identical samples needed to accept a level change (>=1)
//     REPEAT_DELAY    : cycles from accepted press to first repeat (>=1)
//     REPEAT_PERIOD   : cycles between subsequent repeats (>=1)
//
//   Ports
//     i_clk     : system clock, rising edge
//     i_rst_n   : asynchronous active-low reset
//     i_btn_s   : synchronized button level, 1 = pressed
//     i_rpt_en  : enables the repeat strobe (counting continues when low)
//     o_level   : debounced level
//     o_press   : one-cycle strobe on accepted 0->1
//     o_release : one-cycle strobe on accepted 1->0
//     o_rpt     : one-cycle auto-repeat strobe while held
//
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module btn_conditioner
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_s,
    input  logic i_rpt_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_rpt
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int TM_W = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                    REPEAT_DELAY : REPEAT_PERIOD);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] DELAY_LD  = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] PERIOD_LD = TM_W'(REPEAT_PERIOD - 1);

    btn_state_t      r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_rpt;

    logic            w_mismatch;
    logic            w_accept;
    logic            w_press_acc;
    logic            w_rel_acc;
    logic            w_tmr_en;
    logic            w_tc;

    // The debounce count never exceeds DEBOUNCE_CYCLES-1: the sample that
    // would reach DEBOUNCE_CYCLES is the accepting one and clears it instead.
    assign w_mismatch  = (i_btn_s != r_level);
    assign w_accept    = w_mismatch && (r_db_cnt == DB_LAST);
    assign w_press_acc = w_accept && !r_level;
    assign w_rel_acc   = w_accept &&  r_level;

    // The timer only runs while held; in IDLE it is frozen and gets reloaded
    // on the press edge, so the first strobe lands REPEAT_DELAY edges later.
    assign w_tmr_en = (r_state != ST_IDLE);

    pulse_timer #(
        .W (TM_W)
    ) u_rpt_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (w_press_acc),
        .i_load_val   (DELAY_LD),
        .i_en         (w_tmr_en),
        .i_reload_val (PERIOD_LD),
        .o_tc         (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_db_cnt <= '0;
        end else if (!w_mismatch || w_accept) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_rpt     <= 1'b0;
        end else begin
            r_press   <= w_press_acc;
            r_release <= w_rel_acc;
            // A repeat slot on the accepting release edge is swallowed.
            r_rpt     <= w_tc && i_rpt_en && !w_rel_acc;

            if (w_accept) begin
                r_level <= ~r_level;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_press_acc) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_rel_acc) begin
                        r_state <= ST_IDLE;
                    end else if (w_tc) begin
                        r_state <= ST_RPT;
                    end
                end
                ST_RPT: begin
                    if (w_rel_acc) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_rpt     = r_rpt;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//   Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3. Edge numbers in each scenario count
//   from the first edge that samples the new button value (edge 1).
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    logic clk;
    logic rst_n;
    logic btn_s;
    logic rpt_en;
    logic level;
    logic press;
    logic rel;
    logic rpt;

    int n_cmp;
    int n_fail;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_btn_s   (btn_s),
        .i_rpt_en  (rpt_en),
        .o_level   (level),
        .o_press   (press),
        .o_release (rel),
        .o_rpt     (rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int e, input logic obs, input logic want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, want);
        end
    endtask

    task automatic chk4(input string tag, input int e,
                        input logic w_lv, input logic w_pr,
                        input logic w_rl, input logic w_rp);
        chk({tag, ".level"},   e, level, w_lv);
        chk({tag, ".press"},   e, press, w_pr);
        chk({tag, ".release"}, e, rel,   w_rl);
        chk({tag, ".rpt"},     e, rpt,   w_rp);
    endtask

    task automatic idle(input int n);
        btn_s = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        btn_s  = 1'b0;
        rpt_en = 1'b1;

        // Reset state
        #1;
        chk4("reset_t0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk4("reset", e, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        idle(3);
        chk4("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean press, repeats at 14/17/20/23, release at 24 swallows nothing
        // at 23 (in-progress release) and blocks the 26 slot.
        for (int e = 1; e <= 30; e++) begin
            btn_s = (e <= 20);
            tick();
            chk4("press_rel", e,
                 (e >= 4 && e < 24), (e == 4), (e == 24),
                 (e == 14 || e == 17 || e == 20 || e == 23));
        end
        idle(3);

        // Glitch rejection: 3 high, 2 low, repeated
        for (int e = 1; e <= 20; e++) begin
            btn_s = (((e - 1) % 5) < 3);
            tick();
            chk4("glitch", e, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(3);

        // Held with a 3-sample low dip on edges 15..17; release from 25 with a
        // repeat slot at 26 while the release debounce is in progress.
        for (int e = 1; e <= 32; e++) begin
            btn_s = (e <= 24) && !(e >= 15 && e <= 17);
            tick();
            chk4("dip", e,
                 (e >= 4 && e < 28), (e == 4), (e == 28),
                 (e == 14 || e == 17 || e == 20 || e == 23 || e == 26));
        end
        idle(3);

        // rpt_en masked until edge 16
        for (int e = 1; e <= 36; e++) begin
            btn_s  = (e <= 30);
            rpt_en = (e > 16);
            tick();
            chk4("rpt_en", e,
                 (e >= 4 && e < 34), (e == 4), (e == 34),
                 (e == 17 || e == 20 || e == 23 || e == 26 || e == 29 || e == 32));
        end
        rpt_en = 1'b1;
        idle(3);

        // Reset mid-hold: asserted just before edge 15, released before edge 18
        for (int e = 1; e <= 14; e++) begin
            btn_s = 1'b1;
            tick();
            chk4("rst_pre", e, (e >= 4), (e == 4), 1'b0, (e == 14));
        end
        rst_n = 1'b0;
        #1;
        chk4("rst_async", 14, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 15; e <= 17; e++) begin
            tick();
            chk4("rst_hold", e, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        for (int e = 18; e <= 30; e++) begin
            btn_s = (e <= 24);
            tick();
            chk4("rst_post", e, (e >= 21 && e < 28), (e == 21), (e == 28), 1'b0);
        end
        idle(3);

        // Exact-boundary debounce: 4 high samples then low
        for (int e = 1; e <= 20; e++) begin
            btn_s = (e <= 4);
            tick();
            chk4("boundary", e, (e >= 4 && e < 8), (e == 4), (e == 8), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Debounces and edge-processes a button level already synchronized into the `clk` domain by the two-flop synchronizer. It sits directly downstream of that synchronizer and directly upstream of the time/alarm-setting logic. It produces a clean level plus single-cycle `press`, `release`, and auto-repeat strobes. One instance is placed per front-panel button (hour, minute, set, alarm).

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive identical samples required to accept a level change; must be ≥1.
- `REPEAT_DELAY`, default 50000000: cycles from accepted press to first repeat strobe; must be ≥1.
- `REPEAT_PERIOD`, default 12500000: cycles between subsequent repeat strobes; must be ≥1.
- `clk  input  1`: single system clock; all logic on the rising edge.
- `rst_n  input  1`: asynchronous, active-low reset. Assertion clears all state immediately; deassertion is assumed synchronous to `clk` upstream.
- `btn_s  input  1`: synchronized button level (synchronizer output); 1 = pressed.
- `rpt_en  input  1`: enables auto-repeat strobes; sampled every cycle.
- `level  output  1`: debounced button level.
- `press  output  1`: one-cycle strobe on accepted 0→1 of `level`.
- `release  output  1`: one-cycle strobe on accepted 1→0 of `level`.
- `rpt  output  1`: one-cycle auto-repeat strobe while held.

## Operation
- Reset values: `level`, `press`, `release`, `rpt` = 0. Debounce counter and repeat counter = 0. State = IDLE.
- Debounce: the counter increments on each edge where `btn_s != level`. It clears to 0 on any edge where `btn_s == level`. On the edge where the counter would reach `DEBOUNCE_CYCLES`, the following happen together and the counter clears:
  - `level` toggles;
  - the matching strobe (`press` or `release`) asserts for exactly one cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` samples produce no output change and do not disturb the repeat counter.
- States:
  - IDLE (`level`=0) → HOLD on accepted press.
  - HOLD (`level`=1, counting to `REPEAT_DELAY`) → RPT when the count expires; → IDLE on accepted release.
  - RPT (`level`=1, counting `REPEAT_PERIOD`) → IDLE on accepted release.
- Repeat counter: cleared on accepted press. Counts every cycle in HOLD/RPT.
  - In HOLD, `rpt` pulses on the edge `REPEAT_DELAY` cycles after the `press` edge; the counter then reloads.
  - In RPT, `rpt` pulses every `REPEAT_PERIOD` cycles thereafter.
- `rpt_en`=0 masks the `rpt` output only; counting continues. Re-enabling mid-hold resumes on the existing cadence.
- Simultaneous events:
  - If a repeat slot coincides with the accepted-release edge, `release` wins and `rpt` stays 0.
  - A repeat slot during an in-progress (unaccepted) release debounce still emits `rpt`.
- `press`, `release`, and `rpt` are never asserted in the same cycle.
- Counter widths are `$clog2(param+1)`. Counters saturate or clear and never wrap silently.

## Timing
- All outputs are registered; there is no combinational path from `btn_s` to any output.
- Press latency: `btn_s` high sampled on edges k..k+N−1 (N=`DEBOUNCE_CYCLES`) → `level` and `press` high after edge k+N−1.
- The first `rpt` fires `REPEAT_DELAY` edges after the `press` edge. Subsequent `rpt` strobes fire every `REPEAT_PERIOD` edges.
- Release latency is the same as press latency (N identical low samples).
- Reset mid-hold: outputs drop to 0 asynchronously. If `btn_s` is still high after deassertion, a fresh `press` occurs N edges later.

## Structure
- Package `clock_pkg` holds the state encoding localparams (IDLE, HOLD, RPT) and the default timing constants derived from the board clock frequency.
- Optional sub-module `pulse_timer`: a loadable down-counter with terminal-count strobe, reused for the repeat delay and period. The debounce counter stays inline.

## Test plan
- Run with `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, and `rpt_en`=1 unless stated otherwise.
- Clean press: `btn_s` high from edge 1 → `level`=1 and `press`=1 after edge 4 only; `rpt` at edges 14, 17, 20.
- Release with colliding slot: `btn_s` low on edges 21–24 → `rpt` at 23, then `release` at edge 24, `level`=0. No `rpt` at 26.
- Glitch rejection: 3-cycle high pulses separated by lows → `level`, `press`, `release`, `rpt` stay 0 throughout. A 3-cycle low dip while held → no `release`, and `rpt` cadence is unchanged.
- `rpt_en` masking: hold for 30 cycles with `rpt_en`=0 until edge 16 → no `rpt` at 14; `rpt` at 17 and 20.
- Reset mid-hold: `rst_n`=0 at edge 15 with `btn_s` held high → all outputs 0 immediately. Deassert at edge 18 → `press` after edge 21.
- Exact-boundary debounce: `btn_s` high for exactly 4 samples, then low → `press` at edge 4, then `release` 4 edges after the fall. No `rpt`.
